// File: rtl/ibpl_pkg.sv
// rtl/ibpl_pkg.sv - shared types and limits for the interbackplane output pulse generator
package ibpl_pkg;

  typedef enum logic {
    IBPL_IDLE  = 1'b0,
    IBPL_PULSE = 1'b1
  } ibpl_state_t;

  localparam int IBPL_MAX_CH = 8;

endpackage

// File: rtl/ibpl_pulse_chan.sv
// rtl/ibpl_pulse_chan.sv - one output channel: level/pulse FSM, pulse counter, activity hold counter
module ibpl_pulse_chan
  import ibpl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ACT_MS = 50,
  parameter int RETRIG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena_us,
  input  logic             i_ena_ms,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_level,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_out,
  output logic             o_act,
  output logic             o_busy
);

  localparam logic [7:0]       LP_ACT_LOAD = 8'(ACT_MS);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  ibpl_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_out_d;
  logic [7:0]       r_act_cnt;
  logic             r_act;

  logic w_len_ok;
  logic w_reload;
  logic w_rise;

  assign w_len_ok = (i_len != '0);
  assign w_reload = i_trig && (RETRIG != 0) && w_len_ok;
  assign w_rise   = r_out && !r_out_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IBPL_IDLE;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_out_d   <= 1'b0;
      r_act_cnt <= '0;
      r_act     <= 1'b0;
    end else begin
      r_out_d <= r_out;

      // Level mode and disabled channels both abort any pulse; only level mode drives level_in.
      if (!i_mode || !i_en) begin
        r_state <= IBPL_IDLE;
        r_cnt   <= '0;
        r_out   <= i_level && i_en && !i_mode;
      end else begin
        case (r_state)
          IBPL_IDLE: begin
            if (i_trig && w_len_ok) begin
              r_state <= IBPL_PULSE;
              r_cnt   <= i_len;
              r_out   <= 1'b1;
            end else begin
              r_out <= 1'b0;
            end
          end
          IBPL_PULSE: begin
            r_out <= 1'b1;
            if (w_reload) begin
              r_cnt <= i_len;
            end else if (i_ena_us) begin
              if (r_cnt <= LP_ONE) begin
                r_state <= IBPL_IDLE;
                r_cnt   <= '0;
                r_out   <= 1'b0;
              end else begin
                r_cnt <= r_cnt - LP_ONE;
              end
            end
          end
          default: begin
            r_state <= IBPL_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
          end
        endcase
      end

      // Activity hold is independent of enable so the LED keeps showing recent activity.
      if (w_rise) begin
        r_act_cnt <= LP_ACT_LOAD;
        r_act     <= 1'b1;
      end else if (i_ena_ms && (r_act_cnt != '0)) begin
        r_act_cnt <= r_act_cnt - 8'd1;
        if (r_act_cnt == 8'd1) begin
          r_act <= 1'b0;
        end
      end
    end
  end

  assign o_out  = r_out;
  assign o_act  = r_act;
  assign o_busy = (r_state == IBPL_PULSE);

endmodule

// File: rtl/ibpl_out_pulse_gen.sv
// rtl/ibpl_out_pulse_gen.sv - drive word and activity flags for the interbackplane output cardlet
module ibpl_out_pulse_gen
  import ibpl_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int CNT_W    = 16,
  parameter int ACT_MS   = 50,
  parameter int RETRIG   = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             ena_us,
  input  logic             ena_ms,
  input  logic [7:0]       output_enable,
  input  logic [7:0]       mode,
  input  logic [7:0]       level_in,
  input  logic [7:0]       trig_in,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_len,
  output logic [7:0]       internal_out,
  output logic [7:0]       output_act,
  output logic             busy
);

  logic [CNT_W-1:0]       r_len [CHANNELS];
  logic [IBPL_MAX_CH-1:0] w_out;
  logic [IBPL_MAX_CH-1:0] w_act;
  logic [IBPL_MAX_CH-1:0] w_busy;
  logic                   w_unused_bits;

  // Addresses at or above CHANNELS match no entry and are silently dropped.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_len[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_ch == 3'(i)) begin
          r_len[i] <= cfg_len;
        end
      end
    end
  end

  for (genvar g = 0; g < IBPL_MAX_CH; g++) begin : g_ch
    if (g < CHANNELS) begin : g_used
      ibpl_pulse_chan #(
        .CNT_W  (CNT_W),
        .ACT_MS (ACT_MS),
        .RETRIG (RETRIG)
      ) u_chan (
        .i_clk    (clk),
        .i_rst_n  (nReset),
        .i_ena_us (ena_us),
        .i_ena_ms (ena_ms),
        .i_en     (output_enable[g]),
        .i_mode   (mode[g]),
        .i_level  (level_in[g]),
        .i_trig   (trig_in[g]),
        .i_len    (r_len[g]),
        .o_out    (w_out[g]),
        .o_act    (w_act[g]),
        .o_busy   (w_busy[g])
      );
    end else begin : g_unused
      assign w_out[g]  = 1'b0;
      assign w_act[g]  = 1'b0;
      assign w_busy[g] = 1'b0;
    end
  end

  assign w_unused_bits = ^{output_enable, mode, level_in, trig_in};

  assign internal_out = w_out;
  assign output_act   = w_act;
  assign busy         = |w_busy;

endmodule
